// File: rtl/prime_uart_tx.sv
// prime_uart_tx: takes one unsigned WIDTH-bit value per valid/ready handshake,
// converts it to decimal with shift-add-3 and sends the significant digits
// followed by CR LF as 8N1 UART frames on tx.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for a value, in_ready high, tx idle high
// S_CONVERT | WIDTH double-dabble shifts, then one cycle to pick first digit
// S_SEND    | streaming digit / CR / LF frames back-to-back
module prime_uart_tx #(
  parameter int WIDTH        = 16,
  parameter int DIGITS       = 5,
  parameter int CLKS_PER_BIT = 104
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             tx,
  output logic             busy
);

  localparam int BCD_W     = 4 * DIGITS;
  localparam int CHAR_W    = $clog2(DIGITS + 2);
  localparam int BIT_CNT_W = $clog2(CLKS_PER_BIT);
  localparam int CONV_W    = $clog2(WIDTH + 1);

  localparam logic [CHAR_W-1:0]    CHAR_CR  = CHAR_W'(DIGITS);
  localparam logic [CHAR_W-1:0]    CHAR_LF  = CHAR_W'(DIGITS + 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CONV_W-1:0]    CONV_END = CONV_W'(WIDTH);
  localparam logic [3:0]           STOP_IDX = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_SEND} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    shreg_q, shreg_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [CONV_W-1:0]   conv_cnt_q, conv_cnt_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [3:0]          bit_idx_q, bit_idx_d;
  logic [CHAR_W-1:0]   char_idx_q, char_idx_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                in_ready_q, in_ready_d;

  logic [BCD_W-1:0]    dd_adj;
  logic [BCD_W-1:0]    bcd_shift;
  logic [WIDTH-1:0]    shreg_shift;
  logic [CHAR_W-1:0]   first_digit;
  logic [3:0]          nib;
  logic [7:0]          char_byte;
  logic [9:0]          frame;

  // One double-dabble step: add 3 to every nibble >= 5, then shift left.
  always_comb begin
    dd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) dd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    {bcd_shift, shreg_shift} = {dd_adj, shreg_q} << 1;
  end

  // Slot of the most significant non-zero digit; slot DIGITS-1 for value 0.
  always_comb begin
    first_digit = CHAR_W'(DIGITS - 1);
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (bcd_q[4*(DIGITS-1-i) +: 4] != 4'd0) first_digit = CHAR_W'(i);
    end
  end

  // Sequencer: handshake, conversion count, and bit/character stepping.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bcd_d      = bcd_q;
    conv_cnt_d = conv_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    char_idx_d = char_idx_q;
    if (rst) begin
      state_d    = S_IDLE;
      conv_cnt_d = '0;
      bit_cnt_d  = '0;
      bit_idx_d  = '0;
      char_idx_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            shreg_d    = in_data;
            bcd_d      = '0;
            conv_cnt_d = '0;
            state_d    = S_CONVERT;
          end
        end
        S_CONVERT: begin
          if (conv_cnt_q == CONV_END) begin
            state_d    = S_SEND;
            char_idx_d = first_digit;
            bit_idx_d  = '0;
            bit_cnt_d  = '0;
          end else begin
            bcd_d      = bcd_shift;
            shreg_d    = shreg_shift;
            conv_cnt_d = conv_cnt_q + 1'b1;
          end
        end
        S_SEND: begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            if (bit_idx_q == STOP_IDX) begin
              bit_idx_d = '0;
              if (char_idx_q == CHAR_LF) state_d = S_IDLE;
              else char_idx_d = char_idx_q + 1'b1;
            end else begin
              bit_idx_d = bit_idx_q + 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Character for the upcoming cycle; tx is registered from next-state
  // values so the line lines up with the state, not one cycle behind it.
  always_comb begin
    nib = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (char_idx_d == CHAR_W'(i)) nib = bcd_q[4*(DIGITS-1-i) +: 4];
    end
    if (char_idx_d == CHAR_CR)      char_byte = 8'h0D;
    else if (char_idx_d == CHAR_LF) char_byte = 8'h0A;
    else                            char_byte = 8'h30 + {4'h0, nib};
    frame = {1'b1, char_byte, 1'b0};
  end

  // Output flops: idle-high line, busy outside IDLE, ready only in IDLE.
  always_comb begin
    tx_d       = (state_d == S_SEND) ? frame[bit_idx_d] : 1'b1;
    busy_d     = !rst && (state_d != S_IDLE);
    in_ready_d = !rst && (state_d == S_IDLE);
  end

  // State register.
  always_ff @(posedge clk) begin
    state_q    <= state_d;
    shreg_q    <= shreg_d;
    bcd_q      <= bcd_d;
    conv_cnt_q <= conv_cnt_d;
    bit_cnt_q  <= bit_cnt_d;
    bit_idx_q  <= bit_idx_d;
    char_idx_q <= char_idx_d;
    tx_q       <= tx_d;
    busy_q     <= busy_d;
    in_ready_q <= in_ready_d;
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign in_ready = in_ready_q;

endmodule

// File: tb/tb_prime_uart_tx.sv
// Bench for prime_uart_tx: expected characters are queued on acceptance and
// checked by a mid-bit sampling UART receiver.
module tb_prime_uart_tx;

  localparam int CPB = 4;
  localparam int LAT = 17;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        tx;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_starts = 0;

  typedef struct {
    logic [7:0] ch;
    int         exp_start;
  } exp_t;
  exp_t exp_q[$];

  prime_uart_tx #(.WIDTH(16), .DIGITS(5), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .tx(tx), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter: value equals the index of the most recent rising edge.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_msg(input int t_acc, input logic [15:0] v, output int n);
    string s;
    exp_t  e;
    s = $sformatf("%0d", v);
    n = s.len();
    for (int i = 0; i < n; i++) begin
      e.ch = s[i];
      e.exp_start = (i == 0) ? t_acc + LAT : -1;
      exp_q.push_back(e);
    end
    e.ch = 8'h0D; e.exp_start = -1; exp_q.push_back(e);
    e.ch = 8'h0A; e.exp_start = -1; exp_q.push_back(e);
  endtask

  task automatic send(input logic [15:0] v, output int t_acc, output int n);
    int w = 0;
    in_valid = 1'b1;
    in_data  = v;
    while (!in_ready && w < 5000) begin @(posedge clk); #1; w++; end
    check("accept_ready", in_ready, 1);
    @(posedge clk); #1;
    t_acc    = cyc;
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    push_msg(t_acc, v, n);
    check("busy_after_acc", busy, 1);
    check("ready_after_acc", in_ready, 0);
  endtask

  task automatic wait_idle(input int t_acc, input int n);
    int w = 0;
    while (busy && w < 5000) begin @(posedge clk); #1; w++; end
    check("busy_len", cyc - t_acc, LAT + (n + 2) * 10 * CPB);
    check("ready_at_idle", in_ready, 1);
  endtask

  // UART receiver: detect start, sample each bit mid-way, score at stop.
  initial begin
    logic       active;
    int         cnt;
    int         gap;
    int         frame_gap;
    int         start_cyc;
    logic [7:0] rx;
    exp_t       e;
    active = 1'b0; cnt = 0; gap = 0; frame_gap = 0; start_cyc = 0; rx = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0;
        gap = 0;
      end else if (!active) begin
        gap++;
        if (tx == 1'b0) begin
          active = 1'b1;
          cnt = 0;
          start_cyc = cyc;
          frame_gap = gap;
          n_starts++;
        end
      end else begin
        cnt++;
        if (cnt == 2) begin
          check("start_bit", tx, 0);
        end else if (cnt >= 6 && cnt <= 34 && ((cnt - 2) % 4) == 0) begin
          rx[(cnt - 6) / 4] = tx;
        end else if (cnt == 38) begin
          check("stop_bit", tx, 1);
          if (exp_q.size() == 0) begin
            check("spurious_char", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("char", rx, e.ch);
            if (e.exp_start >= 0) check("first_start", start_cyc, e.exp_start);
            else check("b2b_gap", frame_gap, 2);
          end
          active = 1'b0;
          gap = 0;
        end
      end
    end
  end

  initial begin
    int t;
    int n;
    int w;
    int starts_before;
    logic [15:0] vals [6];
    vals = '{16'd2, 16'd0, 16'd10, 16'd30011, 16'd65535, 16'd65521};

    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 16'd9;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_tx", tx, 1);
      check("rst_ready", in_ready, 0);
      check("rst_busy", busy, 0);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("ready_post_rst", in_ready, 1);
    check("busy_post_rst", busy, 0);

    foreach (vals[i]) begin
      send(vals[i], t, n);
      wait_idle(t, n);
    end

    // Backpressure: 5 presented continuously while 3 is in flight.
    in_valid = 1'b1;
    in_data = 16'd3;
    w = 0;
    while (!in_ready && w < 5000) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    t = cyc;
    push_msg(t, 16'd3, n);
    in_data = 16'd5;
    w = 0;
    while (!in_ready && w < 5000) begin @(posedge clk); #1; w++; end
    check("bp_hold_len", cyc - t, LAT + 3 * 10 * CPB);
    @(posedge clk); #1;
    t = cyc;
    in_valid = 1'b0;
    push_msg(t, 16'd5, n);
    check("bp_busy_5", busy, 1);
    wait_idle(t, n);

    // Reset in the middle of the second character's data bits.
    send(16'd12345, t, n);
    while (cyc < t + LAT + 10 * CPB + 10) begin @(posedge clk); #1; end
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_ready", in_ready, 0);
    starts_before = n_starts;
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("no_starts_after_rst", n_starts - starts_before, 0);
    send(16'd7, t, n);
    wait_idle(t, n);

    repeat (10) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prime_uart_tx.md
Name: prime_uart_tx

Overview:
- Downstream consumer of primogen results on the icestick board.
- Accepts one unsigned WIDTH-bit prime per valid/ready handshake.
- Converts the value to decimal ASCII with leading zeros suppressed and transmits it over a UART TX line (8N1), followed by CR LF.
- Lets the bench stream primes to a host terminal; in_ready doubles as the bench's "fetch next prime" pacing signal.

Parameters:
- WIDTH, 16, bit width of input value; must be 16 or 32.
- DIGITS, 5, max decimal digits; must satisfy 10^DIGITS > 2^WIDTH - 1 (5 for 16, 10 for 32).
- CLKS_PER_BIT, 104, clk cycles per UART bit (12 MHz / 115200); must be ≥ 2.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  in_data holds a value to print
- in_ready  output  1  block can accept a value this cycle
- in_data  input  WIDTH  unsigned value to print
- tx  output  1  UART serial out, idle high
- busy  output  1  high from acceptance until the end of the final LF stop bit

Behaviour:
- Reset values (at the edge where rst=1):
  - tx=1, in_ready=0, busy=0, state=IDLE.
  - in_ready=1 from the first cycle after rst deasserts.
- Handshake:
  - Transfer occurs on an edge where in_valid && in_ready.
  - in_data is captured on that edge.
  - in_ready=0 and busy=1 starting the next cycle.
  - in_ready is high only in IDLE. It is registered, not combinationally dependent on in_valid.
- States: IDLE -> CONVERT -> SEND -> IDLE.
- CONVERT:
  - Double-dabble (shift-add-3) over DIGITS BCD nibbles, one shift per cycle, exactly WIDTH cycles.
  - No combinational divide.
- SEND:
  - Character sequence: significant digits MS-first, then 0x0D, then 0x0A.
  - Leading zero nibbles are skipped; internal and trailing zeros are sent.
  - Value 0 sends a single "0".
  - Digit byte = 0x30 + nibble.
- Frame format per character:
  - Start bit 0, 8 data bits LSB first, stop bit 1.
  - Each bit is held exactly CLKS_PER_BIT cycles.
- Latency:
  - Acceptance edge T; start bit of the first character drives tx from edge T+WIDTH+1.
  - Characters are back-to-back: the next start bit immediately follows the previous stop bit, with no idle gap.
- Completion:
  - After the LF stop bit's final cycle, state=IDLE and busy=0.
  - in_ready=1 in the next cycle.
  - Total busy time = WIDTH + 1 + (n+2)*10*CLKS_PER_BIT cycles, where n = number of printed digits.
- Arithmetic:
  - BCD register is 4*DIGITS bits.
  - Bit counter spans 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Character index width is ceil(log2(DIGITS+2)).
  - Max value (all ones) must print correctly: 65535 for WIDTH=16, 4294967295 for WIDTH=32.
- Boundary conditions:
  - in_valid while busy: ignored, no capture; the value is held off by in_ready=0.
  - in_data changes after acceptance: no effect.
  - rst during CONVERT or mid-frame: tx=1 on the next edge and the partial character is abandoned. The rest of the reset behaviour is as above, and no residual characters are sent afterwards.
  - rst and in_valid in the same cycle: rst wins, nothing is accepted.
- No error output: every WIDTH-bit value is printable by construction.

Test Plan:
All scenarios use CLKS_PER_BIT=4, WIDTH=16, DIGITS=5. The UART model samples mid-bit.
- Reset: hold rst 3 cycles with in_valid=1 -> tx=1, in_ready=0, busy=0 throughout. in_ready=1 on the first post-reset cycle.
- Single digit: send 2 -> bytes 0x32, 0x0D, 0x0A.
  - First start bit at acceptance+17 cycles.
  - busy for 17+120 cycles, then in_ready=1.
- Zero and internal zeros:
  - Send 0 -> "0\r\n".
  - Send 10 -> "10\r\n".
  - Send 30011 -> "30011\r\n".
- Max and largest prime:
  - Send 65535 -> "65535\r\n".
  - Send 65521 -> "65521\r\n", with frames back-to-back (no idle high between stop and start).
- Backpressure: assert in_valid with 3 then 5 continuously -> 3 is accepted immediately. 5 is accepted only on the first cycle in_ready returns. Output is "3\r\n5\r\n".
- Reset mid-frame: send 12345, assert rst during the 2nd character's data bits -> tx=1 the next cycle, no further start bits. A following send of 7 yields exactly "7\r\n".
